// File: rtl/time_param_timer_if.sv
// Bus for time_param_timer: parameter programming, countdown control and status.
// The lock_err signal exists only when TIME_PARAM_LOCK_EN is defined.
interface time_param_timer_if #(
  parameter int NUM_PARAMS = 4,
  parameter int VAL_W      = 4
);
  localparam int SEL_W = $clog2(NUM_PARAMS);

  // Strobe semantics: reprogram and start_timer are sampled on every rising edge with no
  // ready/ack; a strobe counts once per edge it is high. Status outputs are registered.
  logic [SEL_W-1:0]            param_select;
  logic [VAL_W-1:0]            time_value;
  logic                        reprogram;
  logic [SEL_W-1:0]            interval_sel;
  logic                        start_timer;
  logic [NUM_PARAMS*VAL_W-1:0] param_bus;
  logic [VAL_W-1:0]            remaining;
  logic                        busy;
  logic                        tick;
  logic                        expired;
  logic                        state_dbg;
`ifdef TIME_PARAM_LOCK_EN
  logic                        lock_err;

  modport master (
    output param_select, time_value, reprogram, interval_sel, start_timer,
    input  param_bus, remaining, busy, tick, expired, state_dbg, lock_err
  );
  modport slave (
    input  param_select, time_value, reprogram, interval_sel, start_timer,
    output param_bus, remaining, busy, tick, expired, state_dbg, lock_err
  );
`else
  modport master (
    output param_select, time_value, reprogram, interval_sel, start_timer,
    input  param_bus, remaining, busy, tick, expired, state_dbg
  );
  modport slave (
    input  param_select, time_value, reprogram, interval_sel, start_timer,
    output param_bus, remaining, busy, tick, expired, state_dbg
  );
`endif
endinterface

// File: rtl/time_param_timer.sv
// Programmable interval bank plus seconds countdown with a clk-derived 1 s tick.
// Optional TIME_PARAM_LOCK_EN: reprogramming is refused while a countdown is active.
module time_param_timer #(
  parameter int                          NUM_PARAMS   = 4,
  parameter int                          VAL_W        = 4,
  parameter int                          TICK_DIV     = 100_000_000,
  parameter logic [NUM_PARAMS*VAL_W-1:0] DEFAULT_VALS = {4'd10, 4'd15, 4'd8, 4'd6}
) (
  input  logic              clk,
  input  logic              rst,
  time_param_timer_if.slave bus
);
  localparam int SEL_W = $clog2(NUM_PARAMS);
  localparam int PW    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  typedef enum logic {IDLE = 1'b0, COUNT = 1'b1} state_t;

  state_t           r_state;
  logic [VAL_W-1:0] r_params [NUM_PARAMS];
  logic [PW-1:0]    r_presc;
  logic             r_tick;
  logic             r_busy;
  logic             r_expired;
  logic [VAL_W-1:0] r_remaining;

  logic                        w_wr_valid;
  logic                        w_wr_blocked;
  logic                        w_abort;
  logic                        w_start_ok;
  logic                        w_presc_wrap;
  logic                        w_presc_clr;
  logic [VAL_W-1:0]            w_wr_val;
  logic [NUM_PARAMS*VAL_W-1:0] w_param_bus;

  assign w_wr_valid = bus.reprogram &&
                      ((SEL_W+1)'(bus.param_select) < (SEL_W+1)'(NUM_PARAMS));
  assign w_wr_val   = (bus.time_value == '0) ? VAL_W'(1) : bus.time_value;
  // Reprogram has priority over start on the same edge.
  assign w_start_ok = bus.start_timer && !bus.reprogram &&
                      ((SEL_W+1)'(bus.interval_sel) < (SEL_W+1)'(NUM_PARAMS));

`ifdef TIME_PARAM_LOCK_EN
  logic r_lock_err;
  assign w_wr_blocked = w_wr_valid && r_busy;
  assign w_abort      = 1'b0;
  assign bus.lock_err = r_lock_err;
`else
  assign w_wr_blocked = 1'b0;
  assign w_abort      = w_wr_valid && r_busy;
`endif

  assign w_presc_wrap = (r_presc == PW'(TICK_DIV - 1));
  assign w_presc_clr  = w_start_ok || w_abort;

  always_comb begin
    w_param_bus = '0;
    for (int i = 0; i < NUM_PARAMS; i++) begin
      w_param_bus[i*VAL_W +: VAL_W] = r_params[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_presc     <= '0;
      r_tick      <= 1'b0;
      r_busy      <= 1'b0;
      r_expired   <= 1'b0;
      r_remaining <= '0;
      for (int i = 0; i < NUM_PARAMS; i++) begin
        r_params[i] <= DEFAULT_VALS[i*VAL_W +: VAL_W];
      end
`ifdef TIME_PARAM_LOCK_EN
      r_lock_err <= 1'b0;
`endif
    end else begin
      r_expired <= 1'b0;
`ifdef TIME_PARAM_LOCK_EN
      r_lock_err <= w_wr_blocked;
`endif
      if (w_wr_valid && !w_wr_blocked) begin
        r_params[bus.param_select] <= w_wr_val;
      end

      // Clearing also drops any tick about to be issued so a fresh count gets full seconds.
      if (w_presc_clr) begin
        r_presc <= '0;
        r_tick  <= 1'b0;
      end else if (w_presc_wrap) begin
        r_presc <= '0;
        r_tick  <= 1'b1;
      end else begin
        r_presc <= r_presc + PW'(1);
        r_tick  <= 1'b0;
      end

      if (w_abort) begin
        r_state     <= IDLE;
        r_busy      <= 1'b0;
        r_remaining <= '0;
      end else if (w_start_ok) begin
        r_state     <= COUNT;
        r_busy      <= 1'b1;
        r_remaining <= r_params[bus.interval_sel];
      end else if (r_state == COUNT && r_tick) begin
        if (r_remaining <= VAL_W'(1)) begin
          r_state     <= IDLE;
          r_busy      <= 1'b0;
          r_remaining <= '0;
          r_expired   <= 1'b1;
        end else begin
          r_remaining <= r_remaining - VAL_W'(1);
        end
      end
    end
  end

  assign bus.param_bus = w_param_bus;
  assign bus.remaining = r_remaining;
  assign bus.busy      = r_busy;
  assign bus.tick      = r_tick;
  assign bus.expired   = r_expired;
  assign bus.state_dbg = r_state;
endmodule
